// File: rtl/radar_sim_pkg.sv
// Shared types and defaults for the radar sweep controller family.
package radar_sim_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        FILL,
        READY
    } sweep_state_t;

    localparam int DEF_SIZE        = 3200;
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_CLK_DIV     = 10;
    localparam int DEF_ACP_PER_REV = 4096;

    // Bits needed to hold 'value' (minimum 1).
    function automatic int clogb2(input int value);
        int v;
        int r;
        v = value;
        r = 0;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/sweep_edge_detect.sv
// Rising-edge pulse for a level input; SWEEP_CTRL_SYNC_EN adds a 2-FF synchronizer ahead of the detector.
module sweep_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_in,
    output logic o_edge
);

    logic w_in;
    logic r_in_q;

`ifdef SWEEP_CTRL_SYNC_EN
    logic r_sync1;
    logic r_sync2;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_in = r_sync2;
`else
    assign w_in = i_in;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_in_q <= 1'b0;
        end else begin
            r_in_q <= w_in;
        end
    end

    assign o_edge = w_in & ~r_in_q;

endmodule

// File: rtl/azimuth_sweep_controller.sv
// Sweep sequencer for azimuth_signal_generator: shadow/live bitmap swap, GEN_TRIG, CLK_PE and azimuth tracking.
// Define SWEEP_CTRL_SYNC_EN to synchronize TRIG_IN/ARP_IN/ACP_IN (adds 2 cycles of input latency).
module azimuth_sweep_controller
    import radar_sim_pkg::*;
#(
    parameter int SIZE        = DEF_SIZE,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int ACP_PER_REV = DEF_ACP_PER_REV
) (
    input  logic                                SYS_CLK,
    input  logic                                RST,
    input  logic                                EN,
    input  logic                                TRIG_IN,
    input  logic                                ARP_IN,
    input  logic                                ACP_IN,
    input  logic [WORD_W-1:0]                   S_TDATA,
    input  logic                                S_TVALID,
    output logic                                S_TREADY,
    output logic [SIZE-1:0]                     DATA,
    output logic                                GEN_TRIG,
    output logic                                CLK_PE,
    output logic [clogb2(ACP_PER_REV-1)-1:0]    AZIMUTH,
    output logic [15:0]                         UNDERRUN_CNT,
    output logic                                ARP_LOST
);

    localparam int WORDS = SIZE / WORD_W;
    localparam int IDX_W = clogb2(WORDS - 1);
    localparam int DIV_W = clogb2(CLK_DIV - 1);
    localparam int AZ_W  = clogb2(ACP_PER_REV - 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [AZ_W-1:0]  AZ_MAX   = AZ_W'(ACP_PER_REV - 1);

    sweep_state_t      r_state;
    sweep_state_t      w_state_next;
    logic [IDX_W-1:0]  r_idx;
    logic [SIZE-1:0]   r_shadow;
    logic [SIZE-1:0]   r_data;
    logic              r_gen_trig;
    logic [15:0]       r_underrun;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_next;
    logic              r_clk_pe;
    logic [AZ_W-1:0]   r_az;
    logic              r_arp_lost;
    logic              r_en_q;

    logic w_trig_edge;
    logic w_arp_edge;
    logic w_acp_edge;
    logic w_accept;
    logic w_trig_ok;

    sweep_edge_detect u_trig_edge (.i_clk(SYS_CLK), .i_rst(RST), .i_in(TRIG_IN), .o_edge(w_trig_edge));
    sweep_edge_detect u_arp_edge  (.i_clk(SYS_CLK), .i_rst(RST), .i_in(ARP_IN),  .o_edge(w_arp_edge));
    sweep_edge_detect u_acp_edge  (.i_clk(SYS_CLK), .i_rst(RST), .i_in(ACP_IN),  .o_edge(w_acp_edge));

    // Ready drops with EN in the same cycle so a word presented as EN falls is never taken.
    assign S_TREADY  = EN && (r_state == FILL);
    assign w_accept  = S_TVALID && S_TREADY;
    assign w_trig_ok = EN && w_trig_edge && ((r_state == FILL) || (r_state == READY));

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: next-state gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        if (!EN) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_state_next = SYNC;
                SYNC:    if (w_arp_edge) w_state_next = FILL;
                FILL:    if (w_accept && (r_idx == LAST_IDX)) w_state_next = READY;
                READY:   if (w_trig_edge) w_state_next = FILL;
                default: w_state_next = IDLE;
            endcase
        end
    end

    // NOTE: the shadow buffer has no reset; every word is rewritten before it can be swapped into DATA.
    always_ff @(posedge SYS_CLK) begin
        if (w_accept) begin
            r_shadow[int'(r_idx)*WORD_W +: WORD_W] <= S_TDATA;
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_data     <= '0;
            r_idx      <= '0;
            r_gen_trig <= 1'b0;
            r_underrun <= '0;
        end else begin
            r_gen_trig <= w_trig_ok;
            if (!EN) begin
                r_data <= '0;
                r_idx  <= '0;
            end else if ((r_state == SYNC) && w_arp_edge) begin
                r_idx <= '0;
            end else if (w_trig_ok && (r_state == READY)) begin
                r_data <= r_shadow;
                r_idx  <= '0;
            end else begin
                // A trigger here means FILL: blank the sweep but keep filling where we left off.
                if (w_accept) begin
                    r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
                end
                if (w_trig_ok) begin
                    r_data <= '0;
                    if (r_underrun != 16'hFFFF) begin
                        r_underrun <= r_underrun + 16'd1;
                    end
                end
            end
        end
    end

    assign w_div_next = (r_gen_trig || (r_div == DIV_MAX)) ? '0 : r_div + DIV_W'(1);

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_div    <= '0;
            r_clk_pe <= 1'b0;
        end else if (!EN || (r_state == IDLE) || (r_state == SYNC)) begin
            r_div    <= '0;
            r_clk_pe <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_clk_pe <= (w_div_next == DIV_MAX);
        end
    end

    always_ff @(posedge SYS_CLK or posedge RST) begin
        if (RST) begin
            r_az       <= '0;
            r_arp_lost <= 1'b0;
            r_en_q     <= 1'b0;
        end else begin
            r_en_q <= EN;
            if (w_arp_edge) begin
                r_az <= '0;
            end else if (w_acp_edge) begin
                r_az <= (r_az == AZ_MAX) ? '0 : r_az + AZ_W'(1);
            end
            if (r_en_q && !EN) begin
                r_arp_lost <= 1'b0;
            end else if (!w_arp_edge && w_acp_edge && (r_az == AZ_MAX)) begin
                r_arp_lost <= 1'b1;
            end
        end
    end

    assign DATA         = r_data;
    assign GEN_TRIG     = r_gen_trig;
    assign CLK_PE       = r_clk_pe;
    assign AZIMUTH      = r_az;
    assign UNDERRUN_CNT = r_underrun;
    assign ARP_LOST     = r_arp_lost;

endmodule

// File: tb/tb_azimuth_sweep_controller.sv
// Directed self-checking bench for azimuth_sweep_controller; inputs change and outputs are sampled on the falling edge.
module tb_azimuth_sweep_controller;
    import radar_sim_pkg::*;

    localparam int SIZE   = DEF_SIZE;
    localparam int WORD_W = DEF_WORD_W;
    localparam int WORDS  = SIZE / WORD_W;
    localparam int AZ_W   = clogb2(DEF_ACP_PER_REV - 1);
`ifdef SWEEP_CTRL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic              SYS_CLK;
    logic              RST;
    logic              EN;
    logic              TRIG_IN;
    logic              ARP_IN;
    logic              ACP_IN;
    logic [WORD_W-1:0] S_TDATA;
    logic              S_TVALID;
    logic              S_TREADY;
    logic [SIZE-1:0]   DATA;
    logic              GEN_TRIG;
    logic              CLK_PE;
    logic [AZ_W-1:0]   AZIMUTH;
    logic [15:0]       UNDERRUN_CNT;
    logic              ARP_LOST;

    int n_checks = 0;
    int n_fail   = 0;

    azimuth_sweep_controller dut (
        .SYS_CLK      (SYS_CLK),
        .RST          (RST),
        .EN           (EN),
        .TRIG_IN      (TRIG_IN),
        .ARP_IN       (ARP_IN),
        .ACP_IN       (ACP_IN),
        .S_TDATA      (S_TDATA),
        .S_TVALID     (S_TVALID),
        .S_TREADY     (S_TREADY),
        .DATA         (DATA),
        .GEN_TRIG     (GEN_TRIG),
        .CLK_PE       (CLK_PE),
        .AZIMUTH      (AZIMUTH),
        .UNDERRUN_CNT (UNDERRUN_CNT),
        .ARP_LOST     (ARP_LOST)
    );

    initial SYS_CLK = 1'b0;
    always #5 SYS_CLK = ~SYS_CLK;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic arp;
        logic acp;
        int   exp_az;
        logic exp_lost;
    } az_vec_t;

    az_vec_t az_tab[7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge SYS_CLK);
    endtask

    // Leaves the caller on the cycle where the consequences of the edge are first visible.
    task automatic pulse(input logic trig, input logic arp, input logic acp);
        TRIG_IN = trig;
        ARP_IN  = arp;
        ACP_IN  = acp;
        step();
        TRIG_IN = 1'b0;
        ARP_IN  = 1'b0;
        ACP_IN  = 1'b0;
        repeat (LAT - 1) step();
    endtask

    function automatic logic [WORD_W-1:0] pat(input int set, input int k);
        case (set)
            1:       return 32'h1 << (k % 32);
            2:       return 32'hA500_0000 | 32'(k);
            default: return 32'h0F0F_0000 ^ 32'(k * 7);
        endcase
    endfunction

    function automatic logic [SIZE-1:0] exp_vec(input int set);
        logic [SIZE-1:0] v;
        v = '0;
        for (int k = 0; k < WORDS; k++) v[k*WORD_W +: WORD_W] = pat(set, k);
        return v;
    endfunction

    task automatic send_words(input int set, input int first, input int n);
        int acc;
        acc = 0;
        S_TVALID = 1'b1;
        for (int c = 0; (c < n + 20) && (acc < n); c++) begin
            S_TDATA = pat(set, first + acc);
            if (S_TREADY) acc++;
            step();
        end
        S_TVALID = 1'b0;
        check("words_accepted", 64'(acc), 64'(n));
    endtask

    initial begin
        az_tab[0] = '{1'b0, 1'b1, 1, 1'b0};
        az_tab[1] = '{1'b0, 1'b1, 2, 1'b0};
        az_tab[2] = '{1'b0, 1'b1, 3, 1'b0};
        az_tab[3] = '{1'b1, 1'b0, 0, 1'b0};
        az_tab[4] = '{1'b0, 1'b1, 1, 1'b0};
        az_tab[5] = '{1'b1, 1'b1, 0, 1'b0};
        az_tab[6] = '{1'b0, 1'b1, 1, 1'b0};

        RST = 1'b1; EN = 1'b0; TRIG_IN = 1'b0; ARP_IN = 1'b0; ACP_IN = 1'b0;
        S_TDATA = '0; S_TVALID = 1'b0;
        repeat (2) step();
        check("rst_data", 64'(DATA == '0), 1);
        check("rst_gen_trig", GEN_TRIG, 0);
        check("rst_clk_pe", CLK_PE, 0);
        check("rst_azimuth", AZIMUTH, 0);
        check("rst_underrun", UNDERRUN_CNT, 0);
        check("rst_arp_lost", ARP_LOST, 0);
        check("rst_tready", S_TREADY, 0);
        RST = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            pulse(1'b0, az_tab[i].arp, az_tab[i].acp);
            check($sformatf("az_vec%0d_azimuth", i), AZIMUTH, az_tab[i].exp_az);
            check($sformatf("az_vec%0d_lost", i), ARP_LOST, az_tab[i].exp_lost);
            step();
        end

        // SYNC ignores triggers; ARP opens the fill.
        EN = 1'b1;
        step();
        pulse(1'b1, 1'b0, 1'b0);
        check("sync_trig_ignored", GEN_TRIG, 0);
        step();
        check("sync_tready", S_TREADY, 0);
        pulse(1'b0, 1'b1, 1'b0);
        check("fill_tready", S_TREADY, 1);
        check("arp_zero_az", AZIMUTH, 0);

        // Full sweep, swap, then CLK_PE cadence.
        send_words(1, 0, WORDS);
        check("ready_tready", S_TREADY, 0);
        pulse(1'b1, 1'b0, 1'b0);
        check("swap_gen_trig", GEN_TRIG, 1);
        check("swap_data", 64'(DATA == exp_vec(1)), 1);
        for (int j = 1; j <= 30; j++) begin
            step();
            if (j == 1) check("gen_trig_one_cycle", GEN_TRIG, 0);
            check($sformatf("clk_pe_cyc%0d", j), CLK_PE, 64'((j % 10) == 0));
        end

        // Underrun after 40 words; the fill resumes at word 40.
        send_words(2, 0, 40);
        pulse(1'b1, 1'b0, 1'b0);
        check("underrun_gen_trig", GEN_TRIG, 1);
        check("underrun_data_blank", 64'(DATA == '0), 1);
        check("underrun_cnt1", UNDERRUN_CNT, 1);
        step();
        send_words(2, 40, WORDS - 41);
        check("resume_still_filling", S_TREADY, 1);
        send_words(2, WORDS - 1, 1);
        check("resume_ready", S_TREADY, 0);
        pulse(1'b1, 1'b0, 1'b0);
        check("resume_data", 64'(DATA == exp_vec(2)), 1);
        step();

        // Last word accepted in the same cycle as the trigger edge.
        send_words(3, 0, WORDS - LAT);
        S_TVALID = 1'b1;
        for (int i = 0; i < LAT; i++) begin
            S_TDATA = pat(3, WORDS - LAT + i);
            TRIG_IN = (i == 0);
            step();
        end
        S_TVALID = 1'b0;
        TRIG_IN  = 1'b0;
        check("coinc_gen_trig", GEN_TRIG, 1);
        check("coinc_data_blank", 64'(DATA == '0), 1);
        check("coinc_underrun2", UNDERRUN_CNT, 2);
        check("coinc_ready", S_TREADY, 0);
        step();
        pulse(1'b1, 1'b0, 1'b0);
        check("coinc_word_stored", 64'(DATA == exp_vec(3)), 1);
        check("coinc_underrun_held", UNDERRUN_CNT, 2);
        step();

        // Azimuth wrap with no ARP.
        pulse(1'b0, 1'b1, 1'b0);
        step();
        for (int i = 0; i < DEF_ACP_PER_REV - 1; i++) begin
            pulse(1'b0, 1'b0, 1'b1);
            step();
        end
        check("az_max", AZIMUTH, DEF_ACP_PER_REV - 1);
        check("az_max_lost", ARP_LOST, 0);
        pulse(1'b0, 1'b0, 1'b1);
        check("az_wrap", AZIMUTH, 0);
        check("az_wrap_lost", ARP_LOST, 1);
        step();

        // EN falls during FILL with a word on the bus.
        send_words(1, 0, 10);
        S_TVALID = 1'b1;
        S_TDATA  = 32'hDEAD_BEEF;
        EN       = 1'b0;
        step();
        S_TVALID = 1'b0;
        check("en_fall_tready", S_TREADY, 0);
        check("en_fall_data", 64'(DATA == '0), 1);
        check("en_fall_lost_clr", ARP_LOST, 0);
        check("en_fall_underrun_held", UNDERRUN_CNT, 2);
        pulse(1'b1, 1'b0, 1'b0);
        check("idle_no_gen_trig", GEN_TRIG, 0);
        begin
            logic any_pe;
            any_pe = 1'b0;
            for (int j = 0; j < 12; j++) begin
                step();
                any_pe = any_pe | CLK_PE;
            end
            check("idle_clk_pe_quiet", any_pe, 0);
        end

        // Restart, then asynchronous reset mid-sweep.
        EN = 1'b1;
        step();
        pulse(1'b0, 1'b1, 1'b0);
        step();
        send_words(1, 0, WORDS);
        pulse(1'b1, 1'b0, 1'b0);
        check("restart_data", 64'(DATA == exp_vec(1)), 1);
        step();
        for (int i = 0; i < 3; i++) begin
            pulse(1'b0, 1'b0, 1'b1);
            step();
        end
        check("restart_az", AZIMUTH, 3);
        #3;
        RST = 1'b1;
        #1;
        check("async_rst_data", 64'(DATA == '0), 1);
        check("async_rst_az", AZIMUTH, 0);
        check("async_rst_underrun", UNDERRUN_CNT, 0);
        check("async_rst_tready", S_TREADY, 0);
        check("async_rst_gen_trig", GEN_TRIG, 0);
        check("async_rst_clk_pe", CLK_PE, 0);
        check("async_rst_lost", ARP_LOST, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
